// File: rtl/fifo_wr_ctrl_pkg.sv
// Shared async-FIFO helpers: Gray/binary pointer conversion used by both
// the write-side and read-side pointer controllers.
package fifo_wr_ctrl_pkg;

  localparam int unsigned GRAY_W = 32;

  typedef logic [GRAY_W-1:0] gray_word_t;

  // Callers zero-extend narrower pointers; leading zeros convert to zeros.
  function automatic gray_word_t bin2gray(input gray_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic gray_word_t gray2bin(input gray_word_t gray);
    gray_word_t bin;
    bin[GRAY_W-1] = gray[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// Producer-facing and read-domain pointer signals of the FIFO write controller.
interface fifo_wr_ctrl_if #(
  parameter int unsigned ADDRSIZE = 4
);

  logic                winc;
  logic [ADDRSIZE:0]   rptr_g;
  logic                wen;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wptr_g;
  logic                wfull;
  logic                awfull;
  logic [ADDRSIZE:0]   wlevel;
  logic                wovf;

  modport master (
    output winc, rptr_g,
    input  wen, waddr, wptr_g, wfull, awfull, wlevel, wovf
  );

  modport slave (
    input  winc, rptr_g,
    output wen, waddr, wptr_g, wfull, awfull, wlevel, wovf
  );

endinterface

// File: rtl/fifo_wr_ctrl_sync_r2w.sv
// Two-flop synchronizer bringing the Gray read pointer into the write clock
// domain; kept as its own module so CDC constraints can target its flops.
module sync_r2w #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q1_q;
  logic [WIDTH-1:0] q2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1_q <= '0;
      q2_q <= '0;
    end else begin
      q1_q <= d_i;
      q2_q <= q1_q;
    end
  end

  assign q_o = q2_q;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Async-FIFO write-side controller: binary/Gray write pointer, synchronized
// read pointer, registered full/almost-full/level flags and sticky overflow.
module fifo_wr_ctrl
  import fifo_wr_ctrl_pkg::*;
#(
  parameter int unsigned ADDRSIZE  = 4,
  parameter int unsigned AFULL_LVL = 2
) (
  input  logic          wclk,
  input  logic          wrst_n,
  fifo_wr_ctrl_if.slave bus
);

  localparam int unsigned PW        = ADDRSIZE + 1;
  localparam int unsigned DEPTH     = 1 << ADDRSIZE;
  localparam int unsigned AFULL_THR = DEPTH - AFULL_LVL;

  logic [PW-1:0] rq2;
  logic [PW-1:0] rq2_full;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] wbin_q,   wbin_d;
  logic [PW-1:0] wptr_g_q, wptr_g_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic          wfull_q,  wfull_d;
  logic          awfull_q, awfull_d;
  logic          wovf_q,   wovf_d;
  logic          wen_c;

  sync_r2w #(
    .WIDTH (PW)
  ) u_sync_r2w (
    .clk   (wclk),
    .rst_n (wrst_n),
    .d_i   (bus.rptr_g),
    .q_o   (rq2)
  );

  // Next-state pointer and flags, all evaluated against the post-write pointer.
  always_comb begin
    wen_c    = bus.winc & ~wfull_q;
    wbin_d   = wbin_q + PW'(wen_c);
    wptr_g_d = PW'(bin2gray(GRAY_W'(wbin_d)));
    rbin_s   = PW'(gray2bin(GRAY_W'(rq2)));
    // Full when the write pointer is exactly one lap ahead of the read pointer.
    rq2_full = {~rq2[ADDRSIZE:ADDRSIZE-1], rq2[ADDRSIZE-2:0]};
    wfull_d  = (wptr_g_d == rq2_full);
    wlevel_d = wbin_d - rbin_s;
    awfull_d = (wlevel_d >= PW'(AFULL_THR));
    wovf_d   = wovf_q | (bus.winc & wfull_q);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wptr_g_q <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      awfull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_g_q <= wptr_g_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      awfull_q <= awfull_d;
      wovf_q   <= wovf_d;
    end
  end

  assign bus.wen    = wen_c;
  assign bus.waddr  = wbin_q[ADDRSIZE-1:0];
  assign bus.wptr_g = wptr_g_q;
  assign bus.wlevel = wlevel_q;
  assign bus.wfull  = wfull_q;
  assign bus.awfull = awfull_q;
  assign bus.wovf   = wovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: vector table for fill/overflow/drain,
// directed wrap and async-reset sequences, and a randomized scoreboard run.
module tb_fifo_wr_ctrl;

  localparam int unsigned A  = 4;
  localparam int unsigned NV = 22;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fifo_wr_ctrl_if #(.ADDRSIZE(A)) wif ();

  fifo_wr_ctrl #(
    .ADDRSIZE  (A),
    .AFULL_LVL (2)
  ) dut (
    .wclk   (clk),
    .wrst_n (rst_n),
    .bus    (wif)
  );

  typedef struct {
    logic       winc;
    logic [4:0] rptr_g;
    logic       e_wen;
    logic [3:0] e_waddr;
    logic [4:0] e_wptr;
    logic       e_full;
    logic       e_afull;
    logic [4:0] e_lvl;
    logic       e_ovf;
  } vec_t;

  vec_t vecs [NV];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [4:0] gray5(input int b);
    logic [4:0] x;
    x = 5'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_regs(input string nm, input logic [3:0] waddr, input logic [4:0] wptr,
                          input logic full, input logic afull, input logic [4:0] lvl,
                          input logic ovf);
    chk({nm, "_waddr"},  32'(wif.waddr),  32'(waddr));
    chk({nm, "_wptr_g"}, 32'(wif.wptr_g), 32'(wptr));
    chk({nm, "_wfull"},  32'(wif.wfull),  32'(full));
    chk({nm, "_awfull"}, 32'(wif.awfull), 32'(afull));
    chk({nm, "_wlevel"}, 32'(wif.wlevel), 32'(lvl));
    chk({nm, "_wovf"},   32'(wif.wovf),   32'(ovf));
  endtask

  initial begin
    int wtot, rcnt, hist1, hist2, m_lvl;
    logic m_full, m_ovf, exp_wen;
    logic [4:0] prev_ptr;

    // Fill 16 words, three dropped writes, then read pointer jumps to 4.
    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{1'b1, 5'd0, 1'b1, 4'((i + 1) % 16), gray5(i + 1),
                  (i == 15), (i >= 13), 5'(i + 1), 1'b0};
    end
    for (int i = 16; i < 19; i++) begin
      vecs[i] = '{1'b1, 5'd0, 1'b0, 4'd0, 5'd24, 1'b1, 1'b1, 5'd16, 1'b1};
    end
    vecs[19] = '{1'b0, 5'd6, 1'b0, 4'd0, 5'd24, 1'b1, 1'b1, 5'd16, 1'b1};
    vecs[20] = '{1'b0, 5'd6, 1'b0, 4'd0, 5'd24, 1'b1, 1'b1, 5'd16, 1'b1};
    vecs[21] = '{1'b0, 5'd6, 1'b0, 4'd0, 5'd24, 1'b0, 1'b0, 5'd12, 1'b1};

    rst_n      = 1'b0;
    wif.winc   = 1'b0;
    wif.rptr_g = '0;
    #1;
    chk_regs("reset", 4'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("reset_wen", 32'(wif.wen), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      wif.winc   = vecs[i].winc;
      wif.rptr_g = vecs[i].rptr_g;
      #1;
      chk($sformatf("v%0d_wen", i), 32'(wif.wen), 32'(vecs[i].e_wen));
      @(posedge clk); #1;
      chk_regs($sformatf("v%0d", i), vecs[i].e_waddr, vecs[i].e_wptr, vecs[i].e_full,
               vecs[i].e_afull, vecs[i].e_lvl, vecs[i].e_ovf);
    end

    // Overflow flag is sticky while idle; then drain to level 9 and pulse reset.
    wif.winc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("ovf_hold", 32'(wif.wovf), 32'd1);
    wif.rptr_g = gray5(7);
    repeat (3) @(posedge clk);
    #1;
    chk("lvl9_wlevel", 32'(wif.wlevel), 32'd9);
    chk("lvl9_wfull",  32'(wif.wfull),  32'd0);
    #2;
    rst_n      = 1'b0;
    wif.rptr_g = '0;
    #1;
    chk_regs("async_rst", 4'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("async_rst_wen", 32'(wif.wen), 32'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Lockstep write/read across the 31->0 pointer wrap.
    wif.winc = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("prefill_wlevel", 32'(wif.wlevel), 32'd3);
    for (int j = 0; j < 40; j++) begin
      wif.winc   = 1'b1;
      wif.rptr_g = gray5(j % 32);
      #1;
      chk($sformatf("ls%0d_wen", j), 32'(wif.wen), 32'd1);
      @(posedge clk); #1;
      chk($sformatf("ls%0d_wfull", j), 32'(wif.wfull), 32'd0);
      if (j >= 2) begin
        chk($sformatf("ls%0d_wlevel", j), 32'(wif.wlevel), 32'd6);
        chk($sformatf("ls%0d_awfull", j), 32'(wif.awfull), 32'd0);
      end
    end
    chk("wrap_waddr",  32'(wif.waddr),  32'd11);
    chk("wrap_wptr_g", 32'(wif.wptr_g), 32'(gray5(43)));

    // Random writes against a model read domain with two-cycle pointer lag.
    wif.winc   = 1'b0;
    wif.rptr_g = '0;
    rst_n      = 1'b0;
    #2;
    rst_n    = 1'b1;
    wtot     = 0;
    rcnt     = 0;
    hist1    = 0;
    hist2    = 0;
    m_full   = 1'b0;
    m_ovf    = 1'b0;
    prev_ptr = '0;
    @(posedge clk); #1;
    for (int c = 0; c < 300; c++) begin
      wif.winc = ($urandom_range(0, 99) < 65);
      if (rcnt < wtot && $urandom_range(0, 1) == 1) rcnt++;
      wif.rptr_g = gray5(rcnt % 32);
      #1;
      exp_wen = wif.winc & ~m_full;
      chk($sformatf("rnd%0d_wen", c), 32'(wif.wen), 32'(exp_wen));
      m_ovf = m_ovf | (wif.winc & m_full);
      @(posedge clk); #1;
      if (exp_wen) wtot++;
      m_lvl  = wtot - hist2;
      m_full = (m_lvl == 16);
      hist2  = hist1;
      hist1  = rcnt;
      chk_regs($sformatf("rnd%0d", c), 4'(wtot % 16), gray5(wtot % 32), m_full,
               (m_lvl >= 14), 5'(m_lvl), m_ovf);
      chk($sformatf("rnd%0d_gray_step", c), 32'($countones(wif.wptr_g ^ prev_ptr)),
          exp_wen ? 32'd1 : 32'd0);
      prev_ptr = wif.wptr_g;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 The block SHALL have parameter ADDRSIZE, default 4: memory address bits; DEPTH = 2^ADDRSIZE.
REQ-002 The block SHALL have parameter AFULL_LVL, default 2: almost-full margin in words; legal range 1..DEPTH-1.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset: wclk  input  1  write-domain clock; wrst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port winc  input  1: write request from the producer.
REQ-005 The block SHALL have port rptr_g  input  ADDRSIZE+1: Gray-coded read pointer from the read clock domain, asynchronous to wclk.
REQ-006 The block SHALL have port wen  output  1: qualified write strobe to the memory write-enable.
REQ-007 The block SHALL have port waddr  output  ADDRSIZE: write address to the memory.
REQ-008 The block SHALL have port wptr_g  output  ADDRSIZE+1: registered Gray write pointer, exported to the read domain.
REQ-009 The block SHALL have port wfull  output  1: FIFO full.
REQ-010 The block SHALL have port awfull  output  1: FIFO almost full.
REQ-011 The block SHALL have port wlevel  output  ADDRSIZE+1: occupancy as seen from the write side.
REQ-012 The block SHALL have port wovf  output  1: sticky overflow flag.

Function
REQ-013 wen SHALL be combinational: wen = winc AND NOT wfull.
REQ-014 The binary write counter wbin (ADDRSIZE+1 bits) SHALL increment by 1 on each wclk edge where wen=1, and SHALL wrap modulo 2^(ADDRSIZE+1).
REQ-015 waddr SHALL equal wbin[ADDRSIZE-1:0], with zero latency relative to the wbin register.
REQ-016 wptr_g SHALL be registered as bin2gray(wbin_next), so that only one bit changes per increment.
REQ-017 rptr_g SHALL pass through a two-flop synchronizer to give rq2; rbin_s = gray2bin(rq2).
REQ-018 wfull SHALL be registered as: gray(wbin_next) == {~rq2[ADDRSIZE:ADDRSIZE-1], rq2[ADDRSIZE-2:0]}.
REQ-019 wlevel SHALL be registered as (wbin_next - rbin_s) modulo 2^(ADDRSIZE+1), with range 0..DEPTH.
REQ-020 awfull SHALL be registered as 1 when the next-state level >= DEPTH-AFULL_LVL, and 0 otherwise.
REQ-021 wfull=1 SHALL imply awfull=1, and wfull=1 SHALL imply wlevel=DEPTH.
REQ-022 Write latency: waddr/wptr_g SHALL advance and wfull/awfull/wlevel SHALL update on the same edge that accepts a write.
REQ-023 Read-side latency: a change on rptr_g SHALL be reflected in wfull/awfull/wlevel no later than the 3rd wclk rising edge after the change.
REQ-024 A write attempted while full (winc=1, wfull=1) SHALL be dropped: no pointer change, wen=0, and wovf set to 1 on that edge.
REQ-025 wovf SHALL stay at 1 until reset; the block SHALL have no other clear path.
REQ-026 A write accepted on the same edge that a freed slot arrives through rq2 SHALL keep level unchanged and wfull/awfull consistent with REQ-018..020.
REQ-027 Pointer wrap from 2^(ADDRSIZE+1)-1 to 0 SHALL NOT cause a spurious full, level, or almost-full indication.

Reset
REQ-028 While wrst_n=0, wbin, wptr_g, both synchronizer stages, wlevel, wfull, awfull and wovf SHALL be 0, asserted asynchronously.
REQ-029 Reset deassertion SHALL be synchronized externally; the first write SHALL be accepted on the first wclk edge with wrst_n=1 and winc=1.
REQ-030 Reset asserted mid-operation SHALL discard all state; the read domain SHALL be reset concurrently by the integrator.

Structure
REQ-031 The bin2gray and gray2bin functions SHALL reside in the shared fifo package, for reuse by the read-side controller.
REQ-032 The two-flop synchronizer SHALL be a separate sub-module, sync_r2w, parameterized by width, so its flops are identifiable for CDC constraints.
REQ-033 All outputs except wen SHALL be driven directly from flops.

Verification (ADDRSIZE=4, DEPTH=16, AFULL_LVL=2, rptr_g held at 0 unless stated)
REQ-034 Reset then 16 back-to-back winc -> waddr 0..15; awfull=1 after the 14th write; wfull=1 and wlevel=16 after the 16th write; wovf=0.
REQ-035 Full state, then winc=1 for 3 cycles -> wen=0, waddr stays 0, wptr_g unchanged, wovf=1 and held until wrst_n pulses low.
REQ-036 Full state, then rptr_g set to gray(4) -> wfull=0, awfull=0, wlevel=12 by the 3rd wclk edge; never earlier than the 2nd edge.
REQ-037 Continuous write/read in lockstep for 40 words -> pointer wraps 31->0 with wfull never asserted and wlevel constant.
REQ-038 wrst_n pulsed low for a half-cycle while wlevel=9 -> all outputs 0 immediately, without waiting for a wclk edge.
REQ-039 On every edge, random winc with rptr_g driven from a model read domain -> scoreboard matches wlevel, no write accepted while wfull=1, and wptr_g changes by exactly 1 Gray bit per increment.
